// File: rtl/system_bus_arbiter.sv
// N-master to one-slave system bus arbiter with an in-order read-ID FIFO that steers read returns.
// Optional feature macro: SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN (round-robin); fixed priority when undefined.
module system_bus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 30,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_write_data,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_byte_enable,
    input  logic [NUM_MASTERS-1:0]                m_read_req,
    input  logic [NUM_MASTERS-1:0]                m_write_req,
    output logic [NUM_MASTERS-1:0]                m_ready,
    output logic [DATA_WIDTH-1:0]                 m_read_data,
    output logic [NUM_MASTERS-1:0]                m_read_data_valid,
    input  logic                                  bus_ready,
    output logic [ADDR_WIDTH-1:0]                 bus_addr,
    output logic [DATA_WIDTH-1:0]                 bus_write_data,
    output logic [DATA_WIDTH/8-1:0]               bus_byte_enable,
    output logic                                  bus_read_req,
    output logic                                  bus_write_req,
    input  logic [DATA_WIDTH-1:0]                 bus_read_data,
    input  logic                                  bus_read_data_valid,
    output logic                                  protocol_error
);
    localparam int ID_W  = $clog2(NUM_MASTERS);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam logic [PTR_W:0] FIFO_DEPTH = (PTR_W+1)'(MAX_OUTSTANDING);

    logic [NUM_MASTERS-1:0] req;
    logic [ID_W-1:0]        gnt_id;
    logic                   gnt_valid;
    logic                   sel_read, sel_write, presented, accept;
    logic                   push, pop, fifo_full, fifo_empty;

    logic                   lock_valid_q, lock_valid_d;
    logic [ID_W-1:0]        lock_id_q, lock_id_d;
    logic [ID_W-1:0]        fifo_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic                   protocol_error_q, protocol_error_d;

    assign req = m_read_req | m_write_req;

`ifdef SYSTEM_BUS_ARBITER_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        if (lock_valid_q) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_id_q;
        end else begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
                if (!gnt_valid && req[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) rr_ptr_d = (int'(gnt_id) == NUM_MASTERS - 1) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    // Descending scan so the lowest requesting index wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        if (lock_valid_q) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_id_q;
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ID_W'(i);
                end
            end
        end
    end
`endif

    always_comb begin
        bus_addr        = '0;
        bus_write_data  = '0;
        bus_byte_enable = '0;
        sel_read        = 1'b0;
        sel_write       = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_id == ID_W'(i)) begin
                bus_addr        = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bus_write_data  = m_write_data[i*DATA_WIDTH +: DATA_WIDTH];
                bus_byte_enable = m_byte_enable[i*BE_W +: BE_W];
                sel_read        = m_read_req[i];
                sel_write       = m_write_req[i];
            end
        end
    end

    assign fifo_full     = (count_q == FIFO_DEPTH);
    assign fifo_empty    = (count_q == '0);
    assign presented     = gnt_valid & (sel_read | sel_write);
    assign bus_read_req  = gnt_valid & sel_read & ~fifo_full;
    assign bus_write_req = gnt_valid & sel_write;
    assign accept        = (bus_read_req | bus_write_req) & bus_ready;
    assign push          = accept & bus_read_req;
    assign pop           = bus_read_data_valid & ~fifo_empty;
    assign m_read_data   = bus_read_data;
    assign protocol_error = protocol_error_q;

    always_comb begin
        m_ready           = '0;
        m_read_data_valid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_ready[i]           = accept && (gnt_id == ID_W'(i));
            m_read_data_valid[i] = pop && (fifo_mem_q[rd_ptr_q] == ID_W'(i));
        end
    end

    // A request blocked by a slave stall or a full FIFO keeps its grant until accepted.
    always_comb begin
        lock_valid_d     = presented & ~accept;
        lock_id_d        = lock_valid_d ? gnt_id : lock_id_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(push);
        rd_ptr_d         = rd_ptr_q + PTR_W'(pop);
        count_d          = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        protocol_error_d = protocol_error_q | (bus_read_data_valid & fifo_empty);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_valid_q     <= 1'b0;
            lock_id_q        <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            lock_valid_q     <= lock_valid_d;
            lock_id_q        <= lock_id_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= gnt_id;
    end

endmodule
